dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Memory-side responder for the accelerator's external DRAM interface.
- Answers the accelerator's ifmap read requests: takes DRAMreadEn/DRAMreadAddr and returns 64-bit ifmap words after a fixed latency.
- Absorbs pooled-result writes: DRAMwriteEn/DRAMwriteAddr/DRAMwriteData.
- Provides a host side port for preloading ifmaps and reading back results. Sits outside the accelerator top as the other end of its DRAM read and write ports.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 64, word width.
- DEPTH, 1024, number of words stored; must not exceed 2^ADDR_W.
- READ_LAT, 1, cycles from a sampled read request to valid data; range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- DRAMreadEn  in  1  accelerator read request.
- DRAMreadAddr  in  ADDR_W  accelerator read address.
- ifmap  out  DATA_W  read data to the accelerator.
- ifmap_valid  out  1  ifmap holds the data for a request issued READ_LAT cycles earlier.
- DRAMwriteEn  in  1  accelerator write strobe.
- DRAMwriteAddr  in  ADDR_W  accelerator write address.
- DRAMwriteData  in  DATA_W  accelerator write data.
- host_req  in  1  host access request.
- host_we  in  1  host write (1) or read (0).
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access accepted this cycle (combinational).
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host read data valid; one-cycle pulse.
- rd_count  out  16  accepted accelerator reads, saturating.
- wr_count  out  16  accepted accelerator writes, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - ifmap, ifmap_valid, host_rdata, host_rvalid, rd_count, wr_count all go to 0.
  - Read pipeline valid bits are cleared; in-flight reads are discarded and never produce ifmap_valid.
  - Memory contents are not reset.
- Arbiter FSM, states IDLE, ACCEL, HOST (registered; reset to IDLE):
  - ACCEL when DRAMreadEn or DRAMwriteEn is sampled high.
  - HOST when host_gnt is high.
  - Otherwise IDLE.
  - The state is informational only; host_gnt is computed combinationally.
- Priority:
  - Accelerator always wins.
  - host_gnt = host_req & ~DRAMreadEn & ~DRAMwriteEn.
  - The host holds its request until granted.
- Accelerator read:
  - Sampled when DRAMreadEn=1. The word at DRAMreadAddr enters a READ_LAT-deep pipeline.
  - ifmap and ifmap_valid=1 appear exactly READ_LAT cycles later.
  - Back-to-back reads every cycle are supported at full throughput.
- Accelerator write: memory is updated at the clock edge where DRAMwriteEn=1.
- Read and write in the same cycle:
  - Same address: write-first; the read returns DRAMwriteData.
  - Different addresses: both complete.
- Host write: memory updated when granted.
- Host read:
  - Data on host_rdata with host_rvalid=1 one cycle after grant.
  - host_rdata holds its value until the next host read.
- Address rules:
  - Addresses >= DEPTH: writes are dropped and reads return 0.
  - The access still counts and is still answered with valid.
- Counters:
  - Increment by 1 per accepted access.
  - Hold at 16'hFFFF.
  - Host accesses are not counted.
- ifmap when not valid: 0 (default build).

Optional Feature:
- Macro: DRAM_RD_HOLD_EN.
- Defined: ifmap retains the last valid read word while ifmap_valid=0. The value still clears to 0 on reset.
- Undefined: ifmap is forced to 0 on every cycle where ifmap_valid=0.
- ifmap_valid timing is identical in both builds.

Test Plan:
- Reset then host preload: after rst release, host writes addr 0..3 with 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444...; host_gnt=1 each cycle. Host read of addr 2 -> host_rvalid pulses one cycle later with host_rdata=64'h3333...
- Accelerator read stream: READ_LAT=1, DRAMreadEn high 4 cycles with addr 0,1,2,3 -> ifmap_valid high on cycles 1..4 with the four preloaded words in order; rd_count=4.
- Write-first collision: DRAMwriteEn and DRAMreadEn in the same cycle, both addr 5, write data 64'hDEAD_BEEF_0000_0001 -> ifmap equals that value one cycle later; a later host read of addr 5 returns the same value; wr_count=1.
- Arbitration: host_req held high while DRAMreadEn is high for 3 cycles -> host_gnt=0 for those 3 cycles, then 1 on the first cycle the accelerator is idle. No host access is lost.
- Reset mid-flight: READ_LAT=3, issue a read to addr 1, then drive rst=0 one cycle later -> ifmap_valid never asserts for that read; ifmap=0 and counters=0. Memory addr 1 still reads 64'h2222... afterwards.
- Boundary: read of addr 1023 returns its stored word; with DEPTH=512, a read of addr 600 returns 0 with ifmap_valid=1. rd_count driven past 65535 reads stays at 16'hFFFF. Under DRAM_RD_HOLD_EN, ifmap keeps the last word between reads.

Source files
------------

// File: rtl/dram_responder.sv
// Memory-side responder for the accelerator DRAM port: pipelined reads, writes, host preload/readback.
// Build option DRAM_RD_HOLD_EN: ifmap keeps the last valid read word instead of returning to 0.
module dram_responder #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DRAMreadEn,
  input  logic [ADDR_W-1:0] DRAMreadAddr,
  output logic [DATA_W-1:0] ifmap,
  output logic              ifmap_valid,
  input  logic              DRAMwriteEn,
  input  logic [ADDR_W-1:0] DRAMwriteAddr,
  input  logic [DATA_W-1:0] DRAMwriteData,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAST  = READ_LAT - 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCEL = 2'd1,
    HOST  = 2'd2
  } arb_state_e;

  arb_state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0]   pipe_dat_q [READ_LAT];
  logic [DATA_W-1:0]   pipe_dat_d [READ_LAT];

  logic              host_rd_q, host_rd_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [15:0]       rd_count_q, rd_count_d;
  logic [15:0]       wr_count_q, wr_count_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  // Arbiter: accelerator always wins, host only gets idle cycles
  always_comb begin
    host_gnt = host_req & ~DRAMreadEn & ~DRAMwriteEn;
    state_d  = IDLE;
    if (DRAMreadEn || DRAMwriteEn) begin
      state_d = ACCEL;
    end else if (host_gnt) begin
      state_d = HOST;
    end
  end

  // Single memory write port; accelerator and host writes never coincide
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = DRAMwriteAddr;
    mem_wdata = DRAMwriteData;
    if (DRAMwriteEn) begin
      mem_we = in_range(DRAMwriteAddr);
    end else if (host_gnt && host_we) begin
      mem_we    = in_range(host_addr);
      mem_waddr = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx(mem_waddr)] <= mem_wdata;
    end
  end

  // Write-first forwarding when the accelerator reads the address it is writing
  always_comb begin
    rd_word = '0;
    if (in_range(DRAMreadAddr)) begin
      if (DRAMwriteEn && (DRAMwriteAddr == DRAMreadAddr)) begin
        rd_word = DRAMwriteData;
      end else begin
        rd_word = mem_q[idx(DRAMreadAddr)];
      end
    end
  end

  always_comb begin
    pipe_vld_d[0] = DRAMreadEn;
    pipe_dat_d[0] = rd_word;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
    if (!pipe_vld_d[LAST]) begin
`ifdef DRAM_RD_HOLD_EN
      pipe_dat_d[LAST] = pipe_dat_q[LAST];
`else
      pipe_dat_d[LAST] = '0;
`endif
    end
  end

  always_comb begin
    host_rd_d    = host_gnt & ~host_we;
    host_rdata_d = host_rdata_q;
    if (host_rd_d) begin
      host_rdata_d = in_range(host_addr) ? mem_q[idx(host_addr)] : '0;
    end
  end

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (DRAMreadEn && (rd_count_q != 16'hFFFF)) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (DRAMwriteEn && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pipe_vld_q   <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_dat_q[i] <= '0;
      end
      host_rd_q    <= 1'b0;
      host_rdata_q <= '0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      pipe_vld_q   <= pipe_vld_d;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_dat_q[i] <= pipe_dat_d[i];
      end
      host_rd_q    <= host_rd_d;
      host_rdata_q <= host_rdata_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign ifmap       = pipe_dat_q[LAST];
  assign ifmap_valid = pipe_vld_q[LAST];
  // A host read grant always leaves the arbiter in HOST for the following cycle
  assign host_rvalid = host_rd_q & (state_q == HOST);
  assign host_rdata  = host_rdata_q;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: two instances (READ_LAT=1/DEPTH=1024 and READ_LAT=3/DEPTH=512) on shared stimulus.
module tb_dram_responder;

`ifdef DRAM_RD_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DRAMreadEn = 1'b0, DRAMwriteEn = 1'b0;
  logic [9:0]  DRAMreadAddr = '0, DRAMwriteAddr = '0, host_addr = '0;
  logic [63:0] DRAMwriteData = '0, host_wdata = '0;
  logic        host_req = 1'b0, host_we = 1'b0;

  logic [63:0] ifmap_a, ifmap_b, host_rdata_a, host_rdata_b;
  logic        ifmap_valid_a, ifmap_valid_b, host_gnt_a, host_gnt_b, host_rvalid_a, host_rvalid_b;
  logic [15:0] rd_count_a, rd_count_b, wr_count_a, wr_count_b;

  always #5 clk = ~clk;

  dram_responder #(.READ_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .DRAMreadEn(DRAMreadEn), .DRAMreadAddr(DRAMreadAddr),
    .ifmap(ifmap_a), .ifmap_valid(ifmap_valid_a),
    .DRAMwriteEn(DRAMwriteEn), .DRAMwriteAddr(DRAMwriteAddr), .DRAMwriteData(DRAMwriteData),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_a), .host_rdata(host_rdata_a), .host_rvalid(host_rvalid_a),
    .rd_count(rd_count_a), .wr_count(wr_count_a)
  );

  dram_responder #(.DEPTH(512), .READ_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .DRAMreadEn(DRAMreadEn), .DRAMreadAddr(DRAMreadAddr),
    .ifmap(ifmap_b), .ifmap_valid(ifmap_valid_b),
    .DRAMwriteEn(DRAMwriteEn), .DRAMwriteAddr(DRAMwriteAddr), .DRAMwriteData(DRAMwriteData),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_b), .host_rdata(host_rdata_b), .host_rvalid(host_rvalid_b),
    .rd_count(rd_count_b), .wr_count(wr_count_b)
  );

  // Reference model: word arrays plus a ring of issued reads indexed by cycle number
  logic [63:0] md [2][1024];
  bit          rb_v [2][8];
  logic [63:0] rb_d [2][8];
  logic [63:0] last_d [2];
  logic [63:0] hr [2];
  logic [63:0] exp_if [2];
  bit          exp_iv [2];
  bit          hrv;
  int          rc, wc, cyc;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 1024 : 512;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 8; s++) rb_v[k][s] = 1'b0;
      last_d[k] = '0;
      hr[k]     = '0;
      exp_if[k] = '0;
      exp_iv[k] = 1'b0;
    end
    hrv = 1'b0;
    rc  = 0;
    wc  = 0;
  endtask

  task automatic check_all();
    check("ifmap_a", ifmap_a, exp_if[0]);
    check("ifmap_valid_a", 64'(ifmap_valid_a), 64'(exp_iv[0]));
    check("ifmap_b", ifmap_b, exp_if[1]);
    check("ifmap_valid_b", 64'(ifmap_valid_b), 64'(exp_iv[1]));
    check("host_rvalid_a", 64'(host_rvalid_a), 64'(hrv));
    check("host_rvalid_b", 64'(host_rvalid_b), 64'(hrv));
    check("host_rdata_a", host_rdata_a, hr[0]);
    check("host_rdata_b", host_rdata_b, hr[1]);
    check("rd_count_a", 64'(rd_count_a), 64'(rc));
    check("rd_count_b", 64'(rd_count_b), 64'(rc));
    check("wr_count_a", 64'(wr_count_a), 64'(wc));
    check("wr_count_b", 64'(wr_count_b), 64'(wc));
  endtask

  // One clock cycle: drive, check the combinational grant, advance the model, check after the edge
  task automatic tick(input bit re, input int ra, input bit we, input int wa, input logic [63:0] wd,
                      input bit hq, input bit hw, input int ha, input logic [63:0] hd, input bit chk);
    bit          gnt;
    logic [63:0] v;
    int          s;
    DRAMreadEn    = re;
    DRAMreadAddr  = 10'(ra);
    DRAMwriteEn   = we;
    DRAMwriteAddr = 10'(wa);
    DRAMwriteData = wd;
    host_req      = hq;
    host_we       = hw;
    host_addr     = 10'(ha);
    host_wdata    = hd;
    #1;
    gnt = hq & ~re & ~we;
    if (chk) begin
      check("host_gnt_a", 64'(host_gnt_a), 64'(gnt));
      check("host_gnt_b", 64'(host_gnt_b), 64'(gnt));
    end
    for (int k = 0; k < 2; k++) begin
      v = '0;
      if (ra < dep(k)) v = (we && wa == ra) ? wd : md[k][ra];
      rb_v[k][cyc % 8] = re;
      rb_d[k][cyc % 8] = v;
      if (we && wa < dep(k)) md[k][wa] = wd;
      if (gnt && hw && ha < dep(k)) md[k][ha] = hd;
      if (gnt && !hw) hr[k] = (ha < dep(k)) ? md[k][ha] : 64'd0;
    end
    hrv = gnt & ~hw;
    if (re && rc < 65535) rc++;
    if (we && wc < 65535) wc++;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      s = (cyc - lat(k) + 1) % 8;
      exp_iv[k] = rb_v[k][s];
      if (rb_v[k][s]) begin
        exp_if[k] = rb_d[k][s];
        last_d[k] = rb_d[k][s];
      end else begin
        exp_if[k] = HOLD ? last_d[k] : 64'd0;
      end
    end
    cyc++;
    if (chk) check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, '0, 0, 0, 0, '0, 1);
  endtask

  initial begin
    bit          hq_p, hw_p, re, we;
    int          ha_p, ra, wa;
    logic [63:0] hd_p, w;

    cyc = 8;
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill all of memory so every later read has a known value
    for (int a = 0; a < 1024; a++) tick(0, 0, 0, 0, '0, 1, 1, a, {$urandom, $urandom}, 1);

    for (int i = 0; i < 4; i++) begin
      w = {16{4'(i + 1)}};
      tick(0, 0, 0, 0, '0, 1, 1, i, w, 1);
    end
    tick(0, 0, 0, 0, '0, 1, 0, 2, '0, 1);
    check("preload_rvalid", 64'(host_rvalid_a), 64'd1);
    check("preload_rdata", host_rdata_a, 64'h3333_3333_3333_3333);

    for (int i = 0; i < 4; i++) begin
      tick(1, i, 0, 0, '0, 0, 0, 0, '0, 1);
      w = {16{4'(i + 1)}};
      check("stream_word", ifmap_a, w);
    end
    check("stream_rd_count", 64'(rd_count_a), 64'd4);
    idle(3);

    tick(1, 5, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, '0, 1);
    check("collision_ifmap", ifmap_a, 64'hDEAD_BEEF_0000_0001);
    tick(0, 0, 0, 0, '0, 1, 0, 5, '0, 1);
    check("collision_host", host_rdata_a, 64'hDEAD_BEEF_0000_0001);
    check("collision_wr_count", 64'(wr_count_a), 64'd1);
    idle(2);

    for (int i = 0; i < 3; i++) begin
      tick(1, 10 + i, 0, 0, '0, 1, 0, 7, '0, 1);
      check("arb_blocked", 64'(host_gnt_a), 64'd0);
    end
    tick(0, 0, 0, 0, '0, 1, 0, 7, '0, 1);
    check("arb_rvalid", 64'(host_rvalid_a), 64'd1);
    idle(3);

    tick(1, 1023, 0, 0, '0, 0, 0, 0, '0, 1);
    check("edge_1023", ifmap_a, md[0][1023]);
    tick(1, 600, 0, 0, '0, 0, 0, 0, '0, 1);
    idle(2);
    check("oor_valid_b", 64'(ifmap_valid_b), 64'd1);
    check("oor_data_b", ifmap_b, 64'd0);
    check("hold_a", ifmap_a, HOLD ? 64'(md[0][600]) : 64'd0);
    idle(2);

    // Read in flight in the 3-deep pipe, then asynchronous reset between edges
    tick(1, 1, 0, 0, '0, 0, 0, 0, '0, 1);
    DRAMreadEn = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(4);
    tick(1, 1, 0, 0, '0, 0, 0, 0, '0, 1);
    idle(2);
    check("post_reset_b", ifmap_b, 64'h2222_2222_2222_2222);
    idle(2);

    hq_p = 1'b0; hw_p = 1'b0; ha_p = 0; hd_p = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!hq_p && $urandom_range(0, 9) < 4) begin
        hq_p = 1'b1;
        hw_p = 1'($urandom_range(0, 1));
        ha_p = int'($urandom_range(0, 1023));
        hd_p = {$urandom, $urandom};
      end
      re = ($urandom_range(0, 1) == 1);
      we = ($urandom_range(0, 2) == 0);
      ra = int'($urandom_range(0, 1023));
      wa = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 1023));
      tick(re, ra, we, wa, {$urandom, $urandom}, hq_p, hw_p, ha_p, hd_p, 1);
      if (hq_p && !re && !we) hq_p = 1'b0;
    end
    idle(3);

    for (int i = 0; i < 65540; i++) tick(1, int'($urandom_range(0, 1023)), 0, 0, '0, 0, 0, 0, '0, 0);
    idle(3);
    check("sat_rd_count_a", 64'(rd_count_a), 64'h0000_0000_0000_FFFF);
    check("sat_rd_count_b", 64'(rd_count_b), 64'h0000_0000_0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
